// File: rtl/wallace5x5_pipe.sv
// 5x5 unsigned multiplier, three register stages: partial products, Wallace
// carry-save reduction to two rows, then a final carry-propagate add.

module wallace_ha (
  input  logic a,
  input  logic b,
  output logic carry,
  output logic sum
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module wallace_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic carry,
  output logic sum
);
  assign sum   = a ^ b ^ ci;
  assign carry = (a & b) | (a & ci) | (b & ci);
endmodule

// One 3:2 compression layer. The masks mark which bit positions of each input
// row can ever be non-zero, so each column gets a full adder, a half adder or a
// plain wire, matching the classic Wallace cell count.
module wallace_csa #(
  parameter logic [9:0] XM = 10'h3FF,
  parameter logic [9:0] YM = 10'h3FF,
  parameter logic [9:0] ZM = 10'h3FF
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] z,
  output wire  [9:0] s,
  output wire  [9:0] c
);
  wire [9:0] co;

  for (genvar k = 0; k < 10; k++) begin : g_bit
    if (XM[k] && YM[k] && ZM[k]) begin : g_fa
      wallace_fa u_fa (.a(x[k]), .b(y[k]), .ci(z[k]), .carry(co[k]), .sum(s[k]));
    end else if (XM[k] && YM[k]) begin : g_ha_xy
      wallace_ha u_ha (.a(x[k]), .b(y[k]), .carry(co[k]), .sum(s[k]));
    end else if (XM[k] && ZM[k]) begin : g_ha_xz
      wallace_ha u_ha (.a(x[k]), .b(z[k]), .carry(co[k]), .sum(s[k]));
    end else if (YM[k] && ZM[k]) begin : g_ha_yz
      wallace_ha u_ha (.a(y[k]), .b(z[k]), .carry(co[k]), .sum(s[k]));
    end else begin : g_pass
      assign co[k] = 1'b0;
      assign s[k]  = x[k] | y[k] | z[k];
    end
  end

  assign c = {co[8:0], 1'b0};

  // Dead columns and the top carry are structurally zero for a 5x5 product.
  logic unused_dead;
  assign unused_dead = ^{co[9], x & ~XM, y & ~YM, z & ~ZM};
endmodule

module wallace5x5_pipe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] product,
  output logic       busy
);
  logic [3:1]      vld_pipe_q, vld_pipe_d;
  logic [4:0][4:0] pp_q, pp_d;
  logic [9:0]      sum_q, sum_d, cry_q, cry_d, prod_q, prod_d;
  logic            adv;

  logic [4:0][9:0] row;
  logic [9:0]      s1, c1, s2, c2;
  wire  [9:0]      s1_w, c1_w, s2_w, c2_w, s3_w, c3_w;

  // A stalled output freezes the whole pipe, bubbles included.
  assign adv       = !vld_pipe_q[3] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[3];
  assign product   = prod_q;
  assign busy      = |vld_pipe_q;

  // pp_q[j] is a & b[j], i.e. the partial-product row of weight 2^j.
  always_comb begin
    row = '0;
    for (int j = 0; j < 5; j++) row[j] = 10'(pp_q[j]) << j;
  end

  wallace_csa #(.XM(10'h01F), .YM(10'h03E), .ZM(10'h07C)) u_l1 (
    .x(row[0]), .y(row[1]), .z(row[2]), .s(s1_w), .c(c1_w));
  assign s1 = s1_w;
  assign c1 = c1_w;

  wallace_csa #(.XM(10'h07F), .YM(10'h07C), .ZM(10'h0F8)) u_l2 (
    .x(s1), .y(c1), .z(row[3]), .s(s2_w), .c(c2_w));
  assign s2 = s2_w;
  assign c2 = c2_w;

  wallace_csa #(.XM(10'h0FF), .YM(10'h0F8), .ZM(10'h1F0)) u_l3 (
    .x(s2), .y(c2), .z(row[4]), .s(s3_w), .c(c3_w));

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    pp_d       = pp_q;
    sum_d      = sum_q;
    cry_d      = cry_q;
    prod_d     = prod_q;
    if (adv) begin
      vld_pipe_d = {vld_pipe_q[2:1], in_valid};
      for (int j = 0; j < 5; j++) pp_d[j] = a & {5{b[j]}};
      sum_d      = s3_w;
      cry_d      = c3_w;
      prod_d     = sum_q + cry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      pp_q       <= '0;
      sum_q      <= '0;
      cry_q      <= '0;
      prod_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      pp_q       <= pp_d;
      sum_q      <= sum_d;
      cry_q      <= cry_d;
      prod_q     <= prod_d;
    end
  end
endmodule

// File: tb/tb_wallace5x5_pipe.sv
// Directed checks for wallace5x5_pipe: reset, latency, full operand sweep,
// backpressure, bubbles, mid-flight reset and operand boundaries.

module tb_wallace5x5_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0] a, b;
  logic [9:0] product;

  int n_chk  = 0;
  int n_pass = 0;

  wallace5x5_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    else n_pass++;
  endtask

  // Step to 1ns past the next rising edge, a stable point for checks and drives.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] av, input logic [4:0] bv);
    in_valid = v;
    a        = av;
    b        = bv;
  endtask

  logic [9:0] q[$];
  logic [9:0] xfer[$];
  logic [9:0] e;

  initial begin
    rst_n = 1'b1; out_ready = 1'b1;
    drive(1'b0, 5'd0, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    #19 rst_n = 1'b1;

    // single 31*31: visible after the third rising edge, gone after the fourth
    drive(1'b1, 5'd31, 5'd31);
    tick(); drive(1'b0, 5'd0, 5'd0);
    chk("single_e1_valid", out_valid, 0);
    tick(); chk("single_e2_valid", out_valid, 0);
    tick(); chk("single_e3_valid", out_valid, 1);
    chk("single_e3_product", product, 961);
    chk("single_e3_busy", busy, 1);
    tick(); chk("single_e4_valid", out_valid, 0);
    chk("single_e4_busy", busy, 0);

    // full sweep, back to back
    begin
      int n_out, first_out, last_out;
      n_out = 0; first_out = -1; last_out = -1;
      q.delete();
      for (int cyc = 0; cyc < 1030; cyc++) begin
        if (cyc < 1024) drive(1'b1, cyc[9:5], cyc[4:0]);
        else drive(1'b0, 5'd0, 5'd0);
        if (in_valid && in_ready) begin
          e = {5'd0, a} * {5'd0, b};
          q.push_back(e);
        end
        tick();
        if (out_valid) begin
          if (first_out < 0) first_out = cyc + 1;
          last_out = cyc + 1;
          n_out++;
          if (q.size() == 0) chk("stream_extra", product, 10'h3FF);
          else chk("stream_product", product, q.pop_front());
        end
      end
      chk("stream_count", n_out, 1024);
      chk("stream_first", first_out, 3);
      chk("stream_last", last_out, 1026);
    end

    // backpressure: 15, 63, 0, 31 with a 4-cycle stall on the first result
    begin
      logic       tv[12];
      logic [4:0] ta[12], tb[12];
      logic       tr[12];
      int         n_acc;
      n_acc = 0;
      xfer.delete();
      for (int c = 0; c < 12; c++) begin tv[c] = 1'b0; ta[c] = 5'd0; tb[c] = 5'd0; tr[c] = 1'b1; end
      tv[0] = 1'b1; ta[0] = 5'd3;  tb[0] = 5'd5;
      tv[1] = 1'b1; ta[1] = 5'd7;  tb[1] = 5'd9;
      tv[2] = 1'b1; ta[2] = 5'd0;  tb[2] = 5'd17;
      for (int c = 3; c < 8; c++) begin tv[c] = 1'b1; ta[c] = 5'd31; tb[c] = 5'd1; end
      for (int c = 3; c < 7; c++) tr[c] = 1'b0;
      for (int c = 0; c < 12; c++) begin
        drive(tv[c], ta[c], tb[c]);
        out_ready = tr[c];
        #0;
        if (c >= 3 && c <= 6) begin
          chk("bp_in_ready", in_ready, 0);
          chk("bp_hold_valid", out_valid, 1);
          chk("bp_hold_product", product, 15);
        end
        if (in_valid && in_ready) n_acc++;
        if (out_valid && out_ready) xfer.push_back(product);
        tick();
      end
      out_ready = 1'b1;
      chk("bp_accepts", n_acc, 4);
      chk("bp_xfer_count", xfer.size(), 4);
      if (xfer.size() == 4) begin
        chk("bp_xfer0", xfer[0], 15);
        chk("bp_xfer1", xfer[1], 63);
        chk("bp_xfer2", xfer[2], 0);
        chk("bp_xfer3", xfer[3], 31);
      end
    end

    // bubbles are carried through, not squeezed out
    begin
      logic       ev[4];
      logic [9:0] ep[4];
      ev[0] = 1'b1; ep[0] = 10'd6;
      ev[1] = 1'b0; ep[1] = 10'd0;
      ev[2] = 1'b1; ep[2] = 10'd20;
      ev[3] = 1'b0; ep[3] = 10'd0;
      for (int c = 0; c < 6; c++) begin
        case (c)
          0:       drive(1'b1, 5'd2, 5'd3);
          2:       drive(1'b1, 5'd4, 5'd5);
          default: drive(1'b0, 5'd0, 5'd0);
        endcase
        tick();
        if (c + 1 >= 3) begin
          chk("bubble_valid", out_valid, ev[c - 2]);
          if (ev[c - 2]) chk("bubble_product", product, ep[c - 2]);
        end
      end
    end

    // reset while 12*12 and 5*6 are in flight
    begin
      int n_stale;
      n_stale = 0;
      drive(1'b1, 5'd12, 5'd12); tick();
      drive(1'b1, 5'd5, 5'd6);   tick();
      drive(1'b0, 5'd0, 5'd0);
      chk("midrst_busy_before", busy, 1);
      #3 rst_n = 1'b0; out_ready = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_product", product, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 1);
      #3 rst_n = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (out_valid || product == 10'd144 || product == 10'd30) n_stale++;
      end
      chk("midrst_no_stale", n_stale, 0);
      drive(1'b1, 5'd1, 5'd1); tick();
      drive(1'b0, 5'd0, 5'd0); tick(); tick();
      chk("midrst_after_valid", out_valid, 1);
      chk("midrst_after_product", product, 1);
      tick();
    end

    // operand boundaries, back to back
    begin
      logic [4:0] ba[4], bb[4];
      logic [9:0] bp[4];
      ba[0] = 5'd0;  bb[0] = 5'd31; bp[0] = 10'd0;
      ba[1] = 5'd31; bb[1] = 5'd0;  bp[1] = 10'd0;
      ba[2] = 5'd1;  bb[2] = 5'd31; bp[2] = 10'd31;
      ba[3] = 5'd16; bb[3] = 5'd16; bp[3] = 10'd256;
      for (int c = 0; c < 7; c++) begin
        if (c < 4) drive(1'b1, ba[c], bb[c]);
        else drive(1'b0, 5'd0, 5'd0);
        tick();
        if (c >= 2 && c < 6) begin
          chk("bound_valid", out_valid, 1);
          chk("bound_product", product, bp[c - 2]);
        end
      end
      chk("bound_idle_busy", busy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
